// File: rtl/ysyx_25040111_axi_mem_slave_pkg.sv
// Shared constants for the AXI memory slave: response and burst codes,
// default memory window, FSM state encodings and small decode helpers.
package ysyx_25040111_axi_mem_slave_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  BURST_WRAP  = 2'b10;

    localparam logic [31:0] MEM_BASE    = 32'h8000_0000;
    localparam int          MEM_DEPTH_W = 16;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wr_state_e;

    // WRAP and the reserved encoding are not supported; beats wider than a word are illegal.
    function automatic logic bad_ctrl(input logic [1:0] burst, input logic [2:0] size);
        return (burst == BURST_WRAP) || (burst == 2'b11) || (size > 3'd2);
    endfunction

    // Only INCR moves the address; FIXED (and the error encodings) hold it.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                              input logic [2:0] size);
        return (burst == BURST_INCR) ? a + (32'd1 << size) : a;
    endfunction

endpackage

// File: rtl/ysyx_25040111_axi_mem_slave_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), reloaded with 8'hA5 on reset.
// Supplies the pseudo-random handshake jitter when RANDOM_DELAY_EN is defined.
module ysyx_25040111_lfsr8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] q
);
    logic [7:0] q_q;

    // Shift one step per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q_q <= 8'hA5;
        else if (en) q_q <= {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
    end

    assign q = q_q;
endmodule

// File: rtl/ysyx_25040111_axi_mem_slave.sv
// AXI4 memory responder over a 2**DEPTH_W x 32b word array at BASE_ADDR.
// Independent read and write FSMs, FIXED/INCR bursts, byte strobes, ID echo,
// sticky SLVERR on range/control errors. Define RANDOM_DELAY_EN to add LFSR
// driven handshake jitter; without it timing is fixed and the LFSR is absent.
module ysyx_25040111_axi_mem_slave
    import ysyx_25040111_axi_mem_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = MEM_BASE,
    parameter int          DEPTH_W   = MEM_DEPTH_W,
    parameter int          RD_LAT    = 1,
    parameter int          WR_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid
);
    logic [31:0] mem [0:(1 << DEPTH_W)-1];

    function automatic logic in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (off >> (DEPTH_W + 2)) == 32'd0;
    endfunction

    function automatic logic [DEPTH_W-1:0] widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[DEPTH_W+1:2];
    endfunction

    // Extra delay cycles (rnd) and W-channel stall request.
    logic [1:0] rnd;
    logic       wstall;
`ifdef RANDOM_DELAY_EN
    logic [7:0] lfsr;
    ysyx_25040111_lfsr8 u_lfsr (.clk(clk), .rst_n(rst_n), .en(1'b1), .q(lfsr));
    assign rnd    = lfsr[1:0];
    assign wstall = lfsr[2];
`else
    assign rnd    = 2'd0;
    assign wstall = 1'b0;
`endif

    // ---------------- read channel ----------------
    rd_state_e   rstate_q, rstate_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d, rerr_q, rerr_d;
    logic [31:0] rdata_q, rdata_d, raddr_q, raddr_d;
    logic [1:0]  rresp_q, rresp_d, rburst_q, rburst_d;
    logic [3:0]  rid_q, rid_d;
    logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]  rsize_q, rsize_d;
    logic        rd_bad;

    // A beat errors if the burst was bad at AR time or this beat left the window.
    assign rd_bad = rerr_q || !in_rng(raddr_q);

    // Read state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q <= R_IDLE; arready_q <= 1'b1; rvalid_q <= 1'b0; rlast_q <= 1'b0;
            rerr_q   <= 1'b0;   rdata_q   <= '0;   raddr_q  <= '0;   rresp_q <= '0;
            rburst_q <= '0;     rid_q     <= '0;   rlen_q   <= '0;   rcnt_q  <= '0;
            rsize_q  <= '0;
        end else begin
            rstate_q <= rstate_d; arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
            rerr_q   <= rerr_d;   rdata_q   <= rdata_d;   raddr_q  <= raddr_d;  rresp_q <= rresp_d;
            rburst_q <= rburst_d; rid_q     <= rid_d;     rlen_q   <= rlen_d;   rcnt_q  <= rcnt_d;
            rsize_q  <= rsize_d;
        end
    end

    // Read next-state: accept AR, wait the latency, present and hold each beat.
    always_comb begin
        rstate_d = rstate_q; arready_d = arready_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
        rerr_d   = rerr_q;   rdata_d   = rdata_q;   raddr_d  = raddr_q;  rresp_d = rresp_q;
        rburst_d = rburst_q; rid_d     = rid_q;     rlen_d   = rlen_q;   rcnt_d  = rcnt_q;
        rsize_d  = rsize_q;
        case (rstate_q)
            R_IDLE: begin
                if (arready_q && arvalid) begin
                    raddr_d   = araddr;  rid_d   = arid;    rlen_d = arlen;
                    rsize_d   = arsize;  rburst_d = arburst;
                    rerr_d    = bad_ctrl(arburst, arsize) || !in_rng(araddr);
                    arready_d = 1'b0;
                    rcnt_d    = 8'(RD_LAT - 1) + {6'd0, rnd};
                    rstate_d  = R_WAIT;
                end else if (!arready_q) begin
                    if (rcnt_q == 8'd0) arready_d = 1'b1;
                    else                rcnt_d    = rcnt_q - 8'd1;
                end
            end
            R_WAIT: begin
                if (rcnt_q == 8'd0) begin
                    rdata_d  = rd_bad ? 32'd0 : mem[widx(raddr_q)];
                    rresp_d  = rd_bad ? RESP_SLVERR : RESP_OKAY;
                    rlast_d  = (rlen_q == 8'd0);
                    rvalid_d = 1'b1;
                    rstate_d = R_DATA;
                end else begin
                    rcnt_d = rcnt_q - 8'd1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        arready_d = (rnd == 2'd0);
                        rcnt_d    = {6'd0, rnd} - 8'd1;
                        rstate_d  = R_IDLE;
                    end else begin
                        raddr_d  = next_addr(raddr_q, rburst_q, rsize_q);
                        rlen_d   = rlen_q - 8'd1;
                        rcnt_d   = {6'd0, rnd};
                        rstate_d = R_WAIT;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // ---------------- write channel ----------------
    wr_state_e   wstate_q, wstate_d;
    logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d, werr_q, werr_d;
    logic [31:0] waddr_q, waddr_d;
    logic [1:0]  bresp_q, bresp_d, wburst_q, wburst_d;
    logic [3:0]  bid_q, bid_d, wid_q, wid_d;
    logic [7:0]  wlen_q, wlen_d, wbeat_q, wbeat_d, wcnt_q, wcnt_d;
    logic [2:0]  wsize_q, wsize_d;
    logic        w_fire, w_at_end, w_bad, mem_we;

    assign wready   = wready_q && !wstall;
    assign w_fire   = (wstate_q == W_DATA) && wvalid && wready;
    assign w_at_end = (wbeat_q == wlen_q);
    // wlast must coincide with beat awlen; any disagreement poisons the burst.
    assign w_bad    = !in_rng(waddr_q) || (wlast != w_at_end);
    assign mem_we   = w_fire && !werr_q && !w_bad;

    // Write state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q <= W_IDLE; awready_q <= 1'b1; wready_q <= 1'b0; bvalid_q <= 1'b0;
            werr_q   <= 1'b0;   waddr_q   <= '0;   bresp_q  <= '0;   wburst_q <= '0;
            bid_q    <= '0;     wid_q     <= '0;   wlen_q   <= '0;   wbeat_q  <= '0;
            wcnt_q   <= '0;     wsize_q   <= '0;
        end else begin
            wstate_q <= wstate_d; awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
            werr_q   <= werr_d;   waddr_q   <= waddr_d;   bresp_q  <= bresp_d;  wburst_q <= wburst_d;
            bid_q    <= bid_d;    wid_q     <= wid_d;     wlen_q   <= wlen_d;   wbeat_q  <= wbeat_d;
            wcnt_q   <= wcnt_d;   wsize_q   <= wsize_d;
        end
    end

    // Write next-state: accept AW, consume W beats, wait, then hold B until taken.
    always_comb begin
        wstate_d = wstate_q; awready_d = awready_q; wready_d = wready_q; bvalid_d = bvalid_q;
        werr_d   = werr_q;   waddr_d   = waddr_q;   bresp_d  = bresp_q;  wburst_d = wburst_q;
        bid_d    = bid_q;    wid_d     = wid_q;     wlen_d   = wlen_q;   wbeat_d  = wbeat_q;
        wcnt_d   = wcnt_q;   wsize_d   = wsize_q;
        case (wstate_q)
            W_IDLE: begin
                if (awready_q && awvalid) begin
                    waddr_d   = awaddr;  wid_d    = awid;   wlen_d = awlen;
                    wsize_d   = awsize;  wburst_d = awburst;
                    werr_d    = bad_ctrl(awburst, awsize) || !in_rng(awaddr);
                    wbeat_d   = 8'd0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wstate_d  = W_DATA;
                end else if (!awready_q) begin
                    if (wcnt_q == 8'd0) awready_d = 1'b1;
                    else                wcnt_d    = wcnt_q - 8'd1;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    werr_d  = werr_q || w_bad;
                    waddr_d = next_addr(waddr_q, wburst_q, wsize_q);
                    wbeat_d = wbeat_q + 8'd1;
                    if (wlast || w_at_end) begin
                        wready_d = 1'b0;
                        wcnt_d   = 8'(WR_LAT - 1) + {6'd0, rnd};
                        wstate_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (wcnt_q == 8'd0) begin
                    bvalid_d = 1'b1;
                    bresp_d  = werr_q ? RESP_SLVERR : RESP_OKAY;
                    bid_d    = wid_q;
                    wstate_d = W_RESP;
                end else begin
                    wcnt_d = wcnt_q - 8'd1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = (rnd == 2'd0);
                    wcnt_d    = {6'd0, rnd} - 8'd1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Byte-strobed commit; the array is never reset. A read sampling the same
    // word on this edge sees the pre-write value.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) mem[widx(waddr_q)][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign awready = awready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;

endmodule

// File: tb/tb_ysyx_25040111_axi_mem_slave.sv
// Directed bench for the AXI memory slave: a word-level model of memory and
// of burst/error rules predicts every R and B beat; a negedge monitor compares.
module tb_ysyx_25040111_axi_mem_slave;
    logic        clk = 1'b0, rst_n;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  awid, wstrb, bid, arid, rid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, bresp, arburst, rresp;

    always #5 clk = ~clk;

    ysyx_25040111_axi_mem_slave dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%08h exp=%08h", nm, got, exp);
    endtask

    typedef struct packed { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rbeat_t;
    typedef struct packed { logic [1:0] resp; logic [3:0] id; } bbeat_t;
    rbeat_t rexp[$];
    bbeat_t bexp[$];
    logic [31:0] mm [logic [31:0]];
    logic [31:0] got [0:7];
    logic [31:0] wd [0:7];
    logic [3:0]  ws [0:7];
    logic [1:0]  got_bresp;

    // ---------------- model ----------------
    function automatic bit inr(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8004_0000);
    endfunction

    function automatic logic [31:0] baddr(input logic [31:0] a, input logic [1:0] b,
                                          input logic [2:0] s, input int k);
        return (b == 2'b00) ? a : a + (32'(k) << s);
    endfunction

    function automatic logic [31:0] mrd(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return mm.exists(w) ? mm[w] : 32'h0;
    endfunction

    task automatic model_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                              input logic [2:0] s, input logic [1:0] b);
        bit cerr, bad;
        logic [31:0] ak;
        cerr = (b >= 2'd2) || (s > 3'd2) || !inr(a);
        for (int k = 0; k <= int'(len); k++) begin
            ak  = baddr(a, b, s, k);
            bad = cerr || !inr(ak);
            rexp.push_back('{bad ? 32'h0 : mrd(ak), bad ? 2'b10 : 2'b00, k == int'(len), id});
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                               input logic [2:0] s, input logic [1:0] b, input int wl, input int nsend);
        bit err, bad;
        logic [31:0] ak, v;
        err = (b >= 2'd2) || (s > 3'd2) || !inr(a);
        for (int k = 0; k < nsend; k++) begin
            ak  = baddr(a, b, s, k);
            bad = !inr(ak) || ((k == wl) != (k == int'(len)));
            if (!err && !bad) begin
                v = mrd(ak);
                for (int i = 0; i < 4; i++) if (ws[k][i]) v[8*i +: 8] = wd[k][8*i +: 8];
                mm[{ak[31:2], 2'b00}] = v;
            end
            err = err || bad;
        end
        bexp.push_back('{err ? 2'b10 : 2'b00, id});
    endtask

    // ---------------- monitor ----------------
    logic   hold = 1'b0;
    rbeat_t held;
    always @(negedge clk) begin
        rbeat_t e;
        bbeat_t be;
        if (!rst_n) hold = 1'b0;
        else begin
            if (hold) begin
                chk("r_stall_valid", 32'(rvalid), 32'd1);
                chk("r_stall_data", rdata, held.data);
                chk("r_stall_ctl", {25'd0, rresp, rlast, rid}, {25'd0, held.resp, held.last, held.id});
            end
            if (rvalid && rready) begin
                if (rexp.size() == 0) begin
                    n_chk++;
                    $display("FAIL r_unexpected got=%08h exp=none", rdata);
                end else begin
                    e = rexp.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("rresp", 32'(rresp), 32'(e.resp));
                    chk("rlast", 32'(rlast), 32'(e.last));
                    chk("rid", 32'(rid), 32'(e.id));
                end
            end
            hold = rvalid && !rready;
            held = '{rdata, rresp, rlast, rid};
            if (bvalid && bready) begin
                got_bresp = bresp;
                if (bexp.size() == 0) begin
                    n_chk++;
                    $display("FAIL b_unexpected got=%0d exp=none", bresp);
                end else begin
                    be = bexp.pop_front();
                    chk("bresp", 32'(bresp), 32'(be.resp));
                    chk("bid", 32'(bid), 32'(be.id));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s got=timeout exp=handshake", nm);
    endtask

    task automatic read_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                              input logic [2:0] s, input logic [1:0] b, input logic [15:0] pat);
        bit ok;
        int nb;
        model_read(a, id, len, s, b);
        araddr = a; arid = id; arlen = len; arsize = s; arburst = b; arvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < 32 && !ok; i++) begin @(negedge clk); ok = arready; end
        if (!ok) timeout("ar_ready");
        @(posedge clk); #1 arvalid = 1'b0;
        nb = 0;
        for (int i = 0; i < 64 && nb <= int'(len); i++) begin
            rready = (i < 16) ? pat[i] : 1'b1;
            @(negedge clk);
            if (i == 0) chk("rd_lat0", 32'(rvalid), 32'd0);
            if (i == 1) chk("rd_lat1", 32'(rvalid), 32'd1);
            if (rvalid && rready) begin
                if (nb < 8) got[nb] = rdata;
                nb++;
            end
            @(posedge clk); #1;
        end
        rready = 1'b1;
        if (nb <= int'(len)) timeout("r_beats");
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                               input logic [2:0] s, input logic [1:0] b, input int wl);
        bit ok;
        int nsend;
        nsend = (wl < int'(len)) ? wl + 1 : int'(len) + 1;
        awaddr = a; awid = id; awlen = len; awsize = s; awburst = b; awvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < 32 && !ok; i++) begin @(negedge clk); ok = awready; end
        if (!ok) timeout("aw_ready");
        @(posedge clk); #1 awvalid = 1'b0;
        for (int k = 0; k < nsend; k++) begin
            wdata = wd[k]; wstrb = ws[k]; wlast = (k == wl); wvalid = 1'b1;
            ok = 0;
            for (int i = 0; i < 32 && !ok; i++) begin @(negedge clk); ok = wready; end
            if (!ok) timeout("w_ready");
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        model_write(a, id, len, s, b, wl, nsend);
        ok = 0;
        for (int i = 0; i < 32 && !ok; i++) begin @(negedge clk); ok = bvalid; end
        if (!ok) timeout("b_valid");
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        rst_n = 1'b0; awvalid = 0; wvalid = 0; arvalid = 0; wlast = 0;
        rready = 1'b1; bready = 1'b1;
        awaddr = '0; awid = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
        araddr = '0; arid = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
        wdata = '0; wstrb = '0; got_bresp = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resp", {28'd0, rresp, bresp}, 32'd0);
        chk("rst_ids", {24'd0, rid, bid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single full-word write and read-back
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        write_burst(32'h8000_0004, 4'h3, 8'd0, 3'd2, 2'b01, 0);
        read_burst(32'h8000_0004, 4'h5, 8'd0, 3'd2, 2'b01, 16'hFFFF);
        chk("lit_single", got[0], 32'hDEAD_BEEF);

        // byte strobe merge
        wd[0] = 32'h1122_3344; ws[0] = 4'hF;
        write_burst(32'h8000_0000, 4'h1, 8'd0, 3'd2, 2'b01, 0);
        wd[0] = 32'h0000_AA00; ws[0] = 4'b0010;
        write_burst(32'h8000_0000, 4'h2, 8'd0, 3'd2, 2'b01, 0);
        read_burst(32'h8000_0000, 4'h6, 8'd0, 3'd2, 2'b01, 16'hFFFF);
        chk("lit_strobe", got[0], 32'h1122_AA44);

        // INCR burst write, then INCR read with back-pressure
        for (int k = 0; k < 4; k++) begin wd[k] = 32'hC0DE_0000 | 32'(k); ws[k] = 4'hF; end
        write_burst(32'h8000_0010, 4'h4, 8'd3, 3'd2, 2'b01, 3);
        read_burst(32'h8000_0010, 4'h7, 8'd3, 3'd2, 2'b01, 16'hFFE3);
        chk("lit_incr_b0", got[0], 32'hC0DE_0000);
        chk("lit_incr_b3", got[3], 32'hC0DE_0003);

        // FIXED read repeats the same word
        read_burst(32'h8000_0004, 4'h8, 8'd1, 3'd2, 2'b00, 16'hFFFF);
        chk("lit_fixed_b1", got[1], 32'hDEAD_BEEF);

        // out-of-range start: read errors whole burst, write commits nothing
        read_burst(32'h7FFF_FFFC, 4'hA, 8'd1, 3'd2, 2'b01, 16'hFFFF);
        chk("lit_oor_b1", got[1], 32'h0);
        wd[0] = 32'h9999_9999; wd[1] = 32'h9999_9999; ws[0] = 4'hF; ws[1] = 4'hF;
        write_burst(32'h7FFF_FFFC, 4'hB, 8'd1, 3'd2, 2'b01, 1);
        chk("lit_oor_bresp", 32'(got_bresp), 32'd2);
        read_burst(32'h8000_0000, 4'hC, 8'd0, 3'd2, 2'b01, 16'hFFFF);
        chk("lit_oor_untouched", got[0], 32'h1122_AA44);

        // WRAP burst is rejected
        read_burst(32'h8000_0004, 4'hD, 8'd0, 3'd2, 2'b10, 16'hFFFF);

        // early wlast
        wd[0] = 32'h0BAD_0000; wd[1] = 32'h0BAD_0001; ws[0] = 4'hF; ws[1] = 4'hF;
        write_burst(32'h8000_0020, 4'hE, 8'd2, 3'd2, 2'b01, 1);
        chk("lit_early_wlast", 32'(got_bresp), 32'd2);

        // read sample and write commit on the same edge: old data
        wd[0] = 32'h5566_7788; ws[0] = 4'hF;
        fork
            read_burst(32'h8000_0004, 4'h9, 8'd0, 3'd2, 2'b01, 16'hFFFF);
            write_burst(32'h8000_0004, 4'hF, 8'd0, 3'd2, 2'b01, 0);
        join
        chk("lit_rbw_old", got[0], 32'hDEAD_BEEF);
        read_burst(32'h8000_0004, 4'h1, 8'd0, 3'd2, 2'b01, 16'hFFFF);
        chk("lit_rbw_new", got[0], 32'h5566_7788);

        // asynchronous reset while beat 2 of a burst is stalled
        model_read(32'h8000_0010, 4'h7, 8'd3, 3'd2, 2'b01);
        araddr = 32'h8000_0010; arid = 4'h7; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        @(negedge clk); @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk); @(posedge clk); #1 rready = 1'b0;
        ok = 0;
        for (int i = 0; i < 16 && !ok; i++) begin @(negedge clk); ok = rvalid; end
        if (!ok) timeout("rst_beat2");
        #2 rst_n = 1'b0;
        #1 chk("async_rst_rvalid", 32'(rvalid), 32'd0);
        rexp.delete();
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_arready", 32'(arready), 32'd1);
        chk("post_rst_rvalid", 32'(rvalid), 32'd0);
        rready = 1'b1;
        @(posedge clk); #1;
        read_burst(32'h8000_0004, 4'h2, 8'd0, 3'd2, 2'b01, 16'hFFFF);
        chk("lit_post_rst", got[0], 32'h5566_7788);

        repeat (4) @(posedge clk);
        chk("rexp_drained", 32'(rexp.size()), 32'd0);
        chk("bexp_drained", 32'(bexp.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
